// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// opcodes, FSM states, opcode classes and datapath select codes.
package ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_JALRADR,
    S_JALR,
    S_LUI
  } state_t;

  typedef enum logic [2:0] {
    C_LW,
    C_SW,
    C_R,
    C_I,
    C_BEQ,
    C_JAL,
    C_JALR,
    C_LUI
  } op_class_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/op_class_decoder.sv
// Opcode classifier: op_i -> op_class_o (next-state class),
// imm_src_o (immediate format) and legal_o (supported opcode).
module op_class_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output op_class_t  op_class_o,
  output logic [2:0] imm_src_o,
  output logic       legal_o
);

  always_comb begin
    op_class_o = C_LW;
    imm_src_o  = IMM_I;
    legal_o    = 1'b1;
    unique case (1'b1)
      (op_i == OP_LW): begin
        op_class_o = C_LW;
        imm_src_o  = IMM_I;
      end
      (op_i == OP_SW): begin
        op_class_o = C_SW;
        imm_src_o  = IMM_S;
      end
      (op_i == OP_R): begin
        op_class_o = C_R;
        imm_src_o  = IMM_I;
      end
      (op_i == OP_I): begin
        op_class_o = C_I;
        imm_src_o  = IMM_I;
      end
      (op_i == OP_BEQ): begin
        op_class_o = C_BEQ;
        imm_src_o  = IMM_B;
      end
      (op_i == OP_JAL): begin
        op_class_o = C_JAL;
        imm_src_o  = IMM_J;
      end
      (op_i == OP_JALR): begin
        op_class_o = C_JALR;
        imm_src_o  = IMM_I;
      end
      (op_i == OP_LUI): begin
        op_class_o = C_LUI;
        imm_src_o  = IMM_U;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath.
// Inputs: clk_i, rst_i (async high), op_i, zero_i, mem_ready_i.
// Outputs: datapath selects/enables, branch_o, instr_done_o,
// illegal_o, instr_count_o (retired count, CNT_W bits, wraps).
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on
// mem_ready_i; otherwise mem_ready_i is ignored.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             adr_src_o,
  output logic             ir_write_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       result_src_o,
  output logic [2:0]       imm_src_o,
  output logic [1:0]       alu_op_o,
  output logic             branch_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  op_class_t        op_class;
  logic [2:0]       dec_imm;
  logic             dec_legal;
  logic             rdy;
  ctrl_t            ctl;
  ctrl_t            out;

  op_class_decoder u_dec (
    .op_i       (op_i),
    .op_class_o (op_class),
    .imm_src_o  (dec_imm),
    .legal_o    (dec_legal)
  );

`ifdef MEM_WAIT_EN
  assign rdy = mem_ready_i;
`else
  logic unused_ready;
  assign rdy          = 1'b1;
  assign unused_ready = mem_ready_i;
`endif

  // Strobes of memory states are qualified by rdy so
  // a stalled access fires its write exactly once.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.ir_write   = rdy;
        ctl.pc_update  = rdy;
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        ctl.imm_src   = dec_imm;
        ctl.illegal   = ~dec_legal;
      end
      S_MEMADR, S_JALRADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctl.result_src = RES_RDATA;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.adr_src    = 1'b1;
        ctl.mem_write  = rdy;
        ctl.instr_done = rdy;
      end
      S_EXECR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALU_FUNC;
      end
      S_EXECI: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_FUNC;
      end
      S_ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_RS2;
        ctl.alu_op     = ALU_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.branch     = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_JAL, S_JALR: begin
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_update  = 1'b1;
      end
      S_LUI: begin
        ctl.imm_src    = IMM_U;
        ctl.result_src = RES_IMM;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  // The state already sits at FETCH during reset, so the
  // decoded controls are forced low until rst_i falls.
  assign out = rst_i ? '0 : ctl;

  assign pc_write_o    = out.pc_update
                       | (out.branch & zero_i);
  assign adr_src_o     = out.adr_src;
  assign ir_write_o    = out.ir_write;
  assign mem_write_o   = out.mem_write;
  assign reg_write_o   = out.reg_write;
  assign alu_src_a_o   = out.alu_src_a;
  assign alu_src_b_o   = out.alu_src_b;
  assign result_src_o  = out.result_src;
  assign imm_src_o     = out.imm_src;
  assign alu_op_o      = out.alu_op;
  assign branch_o      = out.branch;
  assign instr_done_o  = out.instr_done;
  assign illegal_o     = out.illegal;
  assign instr_count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      if (ctl.instr_done) begin
        count_q <= count_q + CNT_W'(1);
      end
      case (state_q)
        S_FETCH: begin
          if (rdy) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state_q <= S_FETCH;
          end else begin
            case (op_class)
              C_LW, C_SW: state_q <= S_MEMADR;
              C_R:        state_q <= S_EXECR;
              C_I:        state_q <= S_EXECI;
              C_BEQ:      state_q <= S_BEQ;
              C_JAL:      state_q <= S_JAL;
              C_JALR:     state_q <= S_JALRADR;
              C_LUI:      state_q <= S_LUI;
              default:    state_q <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          if (op_class == C_LW) state_q <= S_MEMREAD;
          else                  state_q <= S_MEMWRITE;
        end
        S_MEMREAD: begin
          if (rdy) state_q <= S_MEMWB;
        end
        S_MEMWRITE: begin
          if (rdy) state_q <= S_FETCH;
        end
        S_MEMWB:   state_q <= S_FETCH;
        S_EXECR:   state_q <= S_ALUWB;
        S_EXECI:   state_q <= S_ALUWB;
        S_ALUWB:   state_q <= S_FETCH;
        S_BEQ:     state_q <= S_FETCH;
        S_JAL:     state_q <= S_ALUWB;
        S_JALRADR: state_q <= S_JALR;
        S_JALR:    state_q <= S_ALUWB;
        S_LUI:     state_q <= S_FETCH;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Checks every output per cycle against a hand-built table.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  // {pcw,adr,ir,mw,rw, a, b, res, imm, aluop, br,done,ill}
  localparam logic [18:0] E_FETCH =
    {5'b10100, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 3'b000};
  localparam logic [18:0] E_MEMADR =
    {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [18:0] E_MEMREAD =
    {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [18:0] E_MEMWB =
    {5'b00001, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 3'b010};
  localparam logic [18:0] E_MEMWRITE =
    {5'b01010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010};
  localparam logic [18:0] E_MW_WAIT =
    {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [18:0] E_EXECR =
    {5'b00000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000};
  localparam logic [18:0] E_EXECI =
    {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b10, 3'b000};
  localparam logic [18:0] E_ALUWB =
    {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010};
  localparam logic [18:0] E_BEQ_Z =
    {5'b10000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b01, 3'b110};
  localparam logic [18:0] E_BEQ_NZ =
    {5'b00000, 2'b10, 2'b00, 2'b00, 3'b000, 2'b01, 3'b110};
  localparam logic [18:0] E_JAL =
    {5'b10000, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [18:0] E_LUI =
    {5'b00001, 2'b00, 2'b00, 2'b11, 3'b100, 2'b00, 3'b010};

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [6:0]    op_i = 7'd0;
  logic          zero_i = 1'b0;
  logic          mem_ready_i = 1'b1;
  logic          pc_write_o;
  logic          adr_src_o;
  logic          ir_write_o;
  logic          mem_write_o;
  logic          reg_write_o;
  logic [1:0]    alu_src_a_o;
  logic [1:0]    alu_src_b_o;
  logic [1:0]    result_src_o;
  logic [2:0]    imm_src_o;
  logic [1:0]    alu_op_o;
  logic          branch_o;
  logic          instr_done_o;
  logic          illegal_o;
  logic [CW-1:0] instr_count_o;
  logic [18:0]   obs;

  int passed = 0;
  int total  = 0;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .op_i          (op_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .ir_write_o    (ir_write_o),
    .mem_write_o   (mem_write_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .result_src_o  (result_src_o),
    .imm_src_o     (imm_src_o),
    .alu_op_o      (alu_op_o),
    .branch_o      (branch_o),
    .instr_done_o  (instr_done_o),
    .illegal_o     (illegal_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write_o, adr_src_o, ir_write_o,
                mem_write_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, result_src_o, imm_src_o,
                alu_op_o, branch_o, instr_done_o,
                illegal_o};

  function automatic logic [18:0] dec(
    input logic [2:0] imm,
    input logic       ill
  );
    return {5'b00000, 2'b01, 2'b01, 2'b00, imm,
            2'b00, 2'b00, ill};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 19'd0)
      $display("FAIL reset_outputs got %b want %b",
               obs, 19'd0);
    else passed++;
    total++;
    if (instr_count_o !== 4'd0)
      $display("FAIL reset_count got %0d want 0",
               instr_count_o);
    else passed++;
    rst_i = 1'b0;
  endtask

  task automatic test_lw();
    logic [18:0] e [5];
    e = '{E_FETCH, dec(3'b000, 1'b0), E_MEMADR,
          E_MEMREAD, E_MEMWB};
    op_i = LW;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL lw_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd1)
      $display("FAIL lw_count got %0d want 1",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_beq();
    logic [18:0] e [6];
    e = '{E_FETCH, dec(3'b010, 1'b0), E_BEQ_Z,
          E_FETCH, dec(3'b010, 1'b0), E_BEQ_NZ};
    op_i = BEQ;
    for (int i = 0; i < 6; i++) begin
      zero_i = (i < 3);
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL beq_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    zero_i = 1'b0;
    #1;
    total++;
    if (instr_count_o !== 4'd3)
      $display("FAIL beq_count got %0d want 3",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] e [7];
    e = '{E_FETCH, dec(3'b011, 1'b0), E_JAL, E_ALUWB,
          E_FETCH, dec(3'b100, 1'b0), E_LUI};
    op_i = JAL;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) op_i = LUI;
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL b2b_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd5)
      $display("FAIL b2b_count got %0d want 5",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [18:0] e [2];
    e = '{E_FETCH, dec(3'b000, 1'b1)};
    op_i = BAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL ill_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd5)
      $display("FAIL ill_count got %0d want 5",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_alu_ops();
    logic [18:0] e [8];
    e = '{E_FETCH, dec(3'b000, 1'b0), E_EXECR, E_ALUWB,
          E_FETCH, dec(3'b000, 1'b0), E_EXECI, E_ALUWB};
    op_i = RT;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) op_i = IT;
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL alu_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd7)
      $display("FAIL alu_count got %0d want 7",
               instr_count_o);
    else passed++;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_sw();
    logic [18:0] e [7];
    logic        r [7];
    e = '{E_FETCH, dec(3'b001, 1'b0), E_MEMADR,
          E_MW_WAIT, E_MW_WAIT, E_MW_WAIT, E_MEMWRITE};
    r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    op_i = SW;
    for (int i = 0; i < 7; i++) begin
      mem_ready_i = r[i];
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL swwait_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    mem_ready_i = 1'b1;
    #1;
    total++;
    if (instr_count_o !== 4'd8)
      $display("FAIL sw_count got %0d want 8",
               instr_count_o);
    else passed++;
  endtask
`else
  task automatic test_sw();
    logic [18:0] e [4];
    e = '{E_FETCH, dec(3'b001, 1'b0), E_MEMADR,
          E_MEMWRITE};
    op_i = SW;
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL sw_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    mem_ready_i = 1'b1;
    #1;
    total++;
    if (instr_count_o !== 4'd8)
      $display("FAIL sw_count got %0d want 8",
               instr_count_o);
    else passed++;
  endtask
`endif

  task automatic test_jalr();
    logic [18:0] e [5];
    e = '{E_FETCH, dec(3'b000, 1'b0), E_MEMADR,
          E_JAL, E_ALUWB};
    op_i = JALR;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL jalr_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd9)
      $display("FAIL jalr_count got %0d want 9",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] e [3];
    logic [18:0] f [4];
    e = '{E_FETCH, dec(3'b001, 1'b0), E_MEMADR};
    f = '{E_FETCH, dec(3'b001, 1'b0), E_MEMADR,
          E_MEMWRITE};
    op_i = SW;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== e[i])
        $display("FAIL rmid_cycle%0d got %b want %b",
                 i, obs, e[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (obs !== E_MEMWRITE)
      $display("FAIL rmid_memwrite got %b want %b",
               obs, E_MEMWRITE);
    else passed++;
    rst_i = 1'b1;
    #1;
    total++;
    if (obs !== 19'd0)
      $display("FAIL rmid_outputs got %b want %b",
               obs, 19'd0);
    else passed++;
    total++;
    if (instr_count_o !== 4'd0)
      $display("FAIL rmid_count got %0d want 0",
               instr_count_o);
    else passed++;
    next_cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== f[i])
        $display("FAIL rmid_after%0d got %b want %b",
                 i, obs, f[i]);
      else passed++;
      next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd1)
      $display("FAIL rmid_recount got %0d want 1",
               instr_count_o);
    else passed++;
  endtask

  task automatic test_wrap();
    op_i = LUI;
    for (int n = 0; n < 14; n++) begin
      repeat (3) next_cycle();
    end
    #1;
    total++;
    if (instr_count_o !== 4'd15)
      $display("FAIL wrap_max got %0d want 15",
               instr_count_o);
    else passed++;
    repeat (3) next_cycle();
    #1;
    total++;
    if (instr_count_o !== 4'd0)
      $display("FAIL wrap_zero got %0d want 0",
               instr_count_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_alu_ops();
    test_sw();
    test_jalr();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
